imem_loader: RTL and testbench

Boot-time instruction-memory loader sitting directly upstream of the single-cycle core. Accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit words, and writes them sequentially from address 0 into the core's instruction RAM write port (RW/address/dataIN). Holds the core in reset until the programme is fully loaded, then releases it.

---
 rtl/loader_pkg.sv | 6 +
 rtl/word_packer.sv | 30 +++
 rtl/imem_loader.sv | 99 +++++++++
 tb/tb_imem_loader.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the instruction-memory loader
package loader_pkg;
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR} state_t;
  localparam int LANES = 4;
  localparam int DEF_TIMEOUT = 1024;
endpackage

// File: rtl/word_packer.sv
// word_packer: packs a byte stream little-endian into 32-bit words
module word_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        strobe,
  input  logic        clear,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_full
);
  localparam int IW = $clog2(LANES);
  logic [IW-1:0] byte_idx;
  // word_full flags the strobe that fills the last lane
  assign word_full = strobe && (byte_idx == IW'(LANES - 1));
  // each strobe drops the byte into the next lane; the index wraps after the last lane
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx <= '0;
      word     <= '0;
    end else if (clear) begin
      byte_idx <= '0;
      word     <= '0;
    end else if (strobe) begin
      word[{byte_idx, 3'b000} +: 8] <= byte_data;
      byte_idx <= byte_idx + IW'(1);
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams bytes into instruction RAM and holds the core in reset until loaded
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_run,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LW    = ADDR_W + 1;
  localparam int TW    = $clog2(TIMEOUT + 1);
  state_t state, nxt;
  logic [LW-1:0] len_q;
  logic [TW-1:0] timer;
  logic accept, word_full, last, start_load, stalled;
  logic ready_d, we_d, busy_d, done_d, err_d;
  assign accept     = byte_valid && byte_ready;
  assign start_load = start && (state == IDLE || state == DONE || state == ERR);
  assign last       = {1'b0, mem_addr} == len_q - LW'(1);
  assign stalled    = !accept && timer == TW'(TIMEOUT - 1);
  word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .strobe    (accept),
    .clear     (start_load),
    .byte_data (byte_data),
    .word      (mem_wdata),
    .word_full (word_full)
  );
  // state, word address, length and idle timer; mem_addr doubles as the word counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      len_q    <= '0;
      timer    <= '0;
      mem_addr <= '0;
    end else begin
      state <= nxt;
      if (start_load) begin
        len_q    <= len;
        timer    <= '0;
        mem_addr <= '0;
      end else begin
        if (state == RECV) timer <= accept ? '0 : timer + TW'(1);
        if (state == WRITE && !last) mem_addr <= mem_addr + ADDR_W'(1);
      end
    end
  end
  // next state: start is only honoured when no load is in progress
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) nxt = len > LW'(DEPTH) ? ERR : len == '0 ? DONE : RECV;
      RECV:            nxt = word_full ? WRITE : stalled ? ERR : RECV;
      WRITE:           nxt = last ? DONE : RECV;
      default:         nxt = IDLE;
    endcase
  end
  // output values for the state being entered, so the outputs themselves are registers
  always_comb begin
    ready_d = nxt == RECV;
    we_d    = nxt == WRITE;
    busy_d  = nxt == RECV || nxt == WRITE;
    done_d  = nxt == DONE;
    err_d   = nxt == ERR;
  end
  // registered handshake, write strobe and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      core_run   <= 1'b0;
      err        <= 1'b0;
    end else begin
      byte_ready <= ready_d;
      mem_we     <= we_d;
      busy       <= busy_d;
      done       <= done_d;
      core_run   <= done_d;
      err        <= err_d;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of the instruction-memory loader
module tb_imem_loader;
  logic clk = 0, rst = 1, start = 0, byte_valid = 0;
  logic [5:0] len = 0;
  logic [7:0] byte_data = 0;
  logic byte_ready, mem_we, core_run, busy, done, err;
  logic [4:0] mem_addr;
  logic [31:0] mem_wdata;
  int total = 0, bad = 0, cyc = 0, nw = 0, nb = 0, c0 = 0;
  logic [31:0] wd [256];
  logic [4:0]  wa [256];
  always #5 clk = ~clk;
  imem_loader #(.ADDR_W(5), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_run(core_run), .busy(busy), .done(done), .err(err)
  );
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst && mem_we && nw < 256) begin
    wa[nw] = mem_addr;
    wd[nw] = mem_wdata;
    nw = nw + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic [5:0] l);
    start = 1;
    len = l;
    step;
    start = 0;
    c0 = cyc;
  endtask
  task automatic send(input logic [7:0] b);
    int i;
    byte_valid = 1;
    byte_data = b;
    for (i = 0; i < 50 && !byte_ready; i++) step;
    if (!byte_ready) chk("send_ready", {31'd0, byte_ready}, 1);
    else step;
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send(w[8*k +: 8]);
  endtask
  task automatic wait_end(input int lim);
    for (int i = 0; i < lim && !done && !err; i++) step;
  endtask
  function automatic logic [31:0] pat(input int w);
    logic [7:0] b;
    b = 8'(w);
    return {b * 8'd3, 8'h5A, ~b, b};
  endfunction
  initial begin
    #2 rst = 0;
    step;
    step;
    chk("rst_out", {byte_ready, mem_we, core_run, busy, done, err}, 0);
    chk("rst_addr", {27'd0, mem_addr}, 0);
    chk("rst_wdata", mem_wdata, 0);
    rst = 1;
    repeat (3) step;
    chk("idle_ready", {31'd0, byte_ready}, 0);
    chk("idle_busy", {31'd0, busy}, 0);
    // basic two-word load
    nb = nw;
    go(2);
    chk("recv_ready", {31'd0, byte_ready}, 1);
    chk("recv_busy", {31'd0, busy}, 1);
    send_word(32'h00100513);
    chk("write_ready_lo", {31'd0, byte_ready}, 0);
    chk("write_we", {31'd0, mem_we}, 1);
    send_word(32'h00200593);
    byte_valid = 0;
    wait_end(100);
    chk("basic_lat", cyc - c0, 10);
    chk("basic_done", {30'd0, done, core_run}, 3);
    chk("basic_busy", {30'd0, busy, err}, 0);
    chk("basic_nw", nw - nb, 2);
    chk("basic_a0", {27'd0, wa[nb]}, 0);
    chk("basic_d0", wd[nb], 32'h00100513);
    chk("basic_a1", {27'd0, wa[nb+1]}, 1);
    chk("basic_d1", wd[nb+1], 32'h00200593);
    // full depth, restarted from DONE
    nb = nw;
    go(32);
    chk("restart_run", {31'd0, core_run}, 0);
    chk("restart_done", {31'd0, done}, 0);
    for (int w = 0; w < 32; w++) send_word(pat(w));
    byte_valid = 0;
    wait_end(400);
    chk("full_lat", cyc - c0, 160);
    chk("full_done", {30'd0, done, core_run}, 3);
    repeat (5) step;
    chk("full_nw", nw - nb, 32);
    for (int w = 0; w < 32; w++) begin
      chk("full_addr", {27'd0, wa[nb+w]}, w);
      chk("full_data", wd[nb+w], pat(w));
    end
    // stall then timeout
    nb = nw;
    go(1);
    send(8'hAA);
    send(8'hBB);
    byte_valid = 0;
    repeat (7) step;
    chk("to_early", {31'd0, err}, 0);
    chk("to_still_busy", {31'd0, busy}, 1);
    step;
    chk("to_err", {31'd0, err}, 1);
    chk("to_run", {30'd0, core_run, busy}, 0);
    chk("to_ready", {31'd0, byte_ready}, 0);
    repeat (3) step;
    chk("to_nw", nw - nb, 0);
    // zero length from ERR, then bad length from DONE
    go(0);
    chk("zero_done", {29'd0, done, core_run, err}, 6);
    chk("zero_nw", nw - nb, 0);
    go(33);
    chk("bad_err", {29'd0, done, core_run, err}, 1);
    chk("bad_busy", {31'd0, busy}, 0);
    // reset in the middle of a load
    nb = nw;
    go(2);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    byte_valid = 0;
    rst = 0;
    #3;
    chk("mid_rst_out", {byte_ready, mem_we, core_run, busy, done, err}, 0);
    rst = 1;
    repeat (6) step;
    chk("mid_rst_idle", {byte_ready, busy, done, err}, 0);
    chk("mid_rst_nw", nw - nb, 0);
    // reload after reset restarts at address 0
    go(1);
    send_word(32'hDEADBEEF);
    byte_valid = 0;
    wait_end(50);
    chk("reload_lat", cyc - c0, 5);
    chk("reload_done", {30'd0, done, core_run}, 3);
    chk("reload_nw", nw - nb, 1);
    chk("reload_a0", {27'd0, wa[nb]}, 0);
    chk("reload_d0", wd[nb], 32'hDEADBEEF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
